// File: rtl/adc_gth_clk_import_seq.sv
// Staggered power-up sequencer for N_CH GTH reference-clock input buffers (IBUFDS_GTE4).
// Optional macro ADC_GTH_CLK_IMPORT_ODIV2_EN routes each buffer's ODIV2 to firmware_clk_div2.
module adc_gth_clk_import_seq #(
    parameter int N_CH       = 4,
    parameter int SETTLE_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] adc_clk_p,
    input  logic [N_CH-1:0] adc_clk_n,
    output logic [N_CH-1:0] firmware_clk,
    output logic [N_CH-1:0] firmware_clk_div2,
    input  logic [N_CH-1:0] en_mask,
    input  logic            restart,
    output logic [N_CH-1:0] clk_good,
    output logic            all_good,
    output logic            busy
);

    localparam int CUR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CUR_W-1:0]   r_cur;
    logic [CUR_W-1:0]   w_cur_nxt;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_nxt;
    logic [N_CH-1:0]    r_active;
    logic [N_CH-1:0]    w_active_nxt;
    logic [N_CH-1:0]    r_good;
    logic [N_CH-1:0]    w_good_nxt;
    logic [N_CH-1:0]    w_pending;
    logic [CUR_W-1:0]   w_pick;

    // Lowest-index channel that is requested but not yet powered
    always_comb begin
        w_pending = en_mask & ~r_active;
        w_pick    = {CUR_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_pick = w_pending[i] ? CUR_W'(i) : w_pick;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cur    <= {CUR_W{1'b0}};
            r_cnt    <= 16'd0;
            r_active <= {N_CH{1'b0}};
            r_good   <= {N_CH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            r_good   <= w_good_nxt;
        end
    end

    // Next-state logic; dropped channels clear in every state, restart overrides all
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active & en_mask;
        w_good_nxt   = r_good & en_mask;
        if (restart) begin
            w_state_nxt  = S_IDLE;
            w_cur_nxt    = {CUR_W{1'b0}};
            w_cnt_nxt    = 16'd0;
            w_active_nxt = {N_CH{1'b0}};
            w_good_nxt   = {N_CH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pending != {N_CH{1'b0}}) begin
                        w_active_nxt[w_pick] = 1'b1;
                        w_cur_nxt            = w_pick;
                        w_cnt_nxt            = 16'(SETTLE_CYC - 1);
                        w_state_nxt          = S_SETTLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (!en_mask[r_cur]) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == 16'd0) begin
                        w_good_nxt[r_cur] = 1'b1;
                        w_state_nxt       = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output decode of registered state
    always_comb begin
        clk_good = r_good;
        busy     = (r_state != S_IDLE);
        all_good = (en_mask != {N_CH{1'b0}}) && (r_good == en_mask);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_buf
        logic w_ceb;
        assign w_ceb = ~r_active[g];
`ifdef ADC_GTH_CLK_IMPORT_ODIV2_EN
        logic w_odiv2;
        assign firmware_clk_div2[g] = w_odiv2;
`else
        // Dangling net: nothing loads ODIV2 in this build
        logic w_odiv2_unused;
        assign firmware_clk_div2[g] = 1'b0;
`endif
        IBUFDS_GTE4 #(
            .REFCLK_EN_TX_PATH (1'b0),
            .REFCLK_HROW_CK_SEL(2'b00),
            .REFCLK_ICNTL_RX   (2'b00)
        ) u_ibuf (
            .I    (adc_clk_p[g]),
            .IB   (adc_clk_n[g]),
            .CEB  (w_ceb),
`ifdef ADC_GTH_CLK_IMPORT_ODIV2_EN
            .ODIV2(w_odiv2),
`else
            .ODIV2(w_odiv2_unused),
`endif
            .O    (firmware_clk[g])
        );
    end

endmodule

`ifndef SYNTHESIS
// Behavioural stand-in for the vendor buffer; the vendor library supplies the real cell in synthesis.
module IBUFDS_GTE4 #(
    parameter logic       REFCLK_EN_TX_PATH  = 1'b0,
    parameter logic [1:0] REFCLK_HROW_CK_SEL = 2'b00,
    parameter logic [1:0] REFCLK_ICNTL_RX    = 2'b00
) (
    input  logic I,
    input  logic IB,
    input  logic CEB,
    output logic O,
    output logic ODIV2
);
    localparam logic RX_ON = (REFCLK_EN_TX_PATH == 1'b0) || (REFCLK_ICNTL_RX != 2'b11);
    assign O     = RX_ON & ~CEB & I & ~IB;
    assign ODIV2 = (REFCLK_HROW_CK_SEL == 2'b00) ? O : 1'b0;
endmodule
`endif

// File: tb/tb_adc_gth_clk_import_seq.sv
// Self-checking bench: event-level channel model compared every cycle, plus literal timing checks.
module tb_adc_gth_clk_import_seq;
    localparam int N  = 4;
    localparam int SC = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] adc_clk_p, adc_clk_n, en_mask;
    logic         restart;
    logic [N-1:0] firmware_clk, firmware_clk_div2, clk_good;
    logic         all_good, busy;

    int total = 0;
    int bad   = 0;

    adc_gth_clk_import_seq #(.N_CH(N), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .adc_clk_p(adc_clk_p), .adc_clk_n(adc_clk_n),
        .firmware_clk(firmware_clk), .firmware_clk_div2(firmware_clk_div2),
        .en_mask(en_mask), .restart(restart), .clk_good(clk_good),
        .all_good(all_good), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: which channels are powered/good, which one is settling and for how long
    typedef struct {
        logic [N-1:0] act;
        logic [N-1:0] good;
        int           settling;
        int           age;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic [N-1:0] en, logic rs);
        mstate_t n = s;
        if (rs) begin
            n.act = '0; n.good = '0; n.settling = -1; n.age = 0;
            return n;
        end
        n.act  = s.act & en;
        n.good = s.good & en;
        if (s.settling >= 0) begin
            if (!en[s.settling]) begin
                n.settling = -1;
            end else if (s.age + 1 == SC) begin
                n.good[s.settling] = 1'b1;
                n.settling = -1;
            end else begin
                n.age = s.age + 1;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (en[c] && !s.act[c] && n.settling < 0) begin
                    n.act[c] = 1'b1;
                    n.settling = c;
                    n.age = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{act: '0, good: '0, settling: -1, age: 0};
        end else begin
            m <= model_next(m, en_mask, restart);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model (inputs only change 2ns after negedge)
    always @(negedge clk) begin
        chk("m_fwclk", 32'(firmware_clk), 32'(m.act & adc_clk_p & ~adc_clk_n));
        chk("m_good",  32'(clk_good), 32'(m.good));
        chk("m_busy",  32'(busy), 32'(m.settling >= 0));
        chk("m_allg",  32'(all_good), 32'((en_mask != '0) && (m.good == en_mask)));
        chk("m_div2",  32'(firmware_clk_div2), 32'd0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller has just set inputs; the next edge is the first enable edge E0
    task automatic seq_check(input string tag);
        step(1);  chk({tag, "_e0_fw"}, 32'(firmware_clk), 32'h1);
                  chk({tag, "_e0_busy"}, 32'(busy), 32'd1);
        step(15); chk({tag, "_e15_good"}, 32'(clk_good), 32'h0);
        step(1);  chk({tag, "_e16_good"}, 32'(clk_good), 32'h1);
                  chk({tag, "_e16_busy"}, 32'(busy), 32'd0);
        step(1);  chk({tag, "_e17_fw"}, 32'(firmware_clk), 32'h3);
        step(49); chk({tag, "_e66_good"}, 32'(clk_good), 32'h7);
                  chk({tag, "_e66_allg"}, 32'(all_good), 32'd0);
        step(1);  chk({tag, "_e67_good"}, 32'(clk_good), 32'hF);
                  chk({tag, "_e67_allg"}, 32'(all_good), 32'd1);
                  chk({tag, "_e67_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en_mask = '0; restart = 1'b0;
        adc_clk_p = '1; adc_clk_n = '0;
        step(3);
        chk("rst_fw", 32'(firmware_clk), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        step(2);
        chk("off_allg", 32'(all_good), 32'd0);
        chk("off_busy", 32'(busy), 32'd0);
        chk("off_div2", 32'(firmware_clk_div2), 32'h0);

        #2 en_mask = 4'b1111;
        seq_check("seq1");

        // Drop ch2 while its counter reads 5
        #2 restart = 1'b1;
        step(1); #2 restart = 1'b0;
        step(45);
        #2 en_mask = 4'b1011;
        step(1); chk("drop_fw", 32'(firmware_clk), 32'h3);
                 chk("drop_good", 32'(clk_good), 32'h3);
                 chk("drop_busy", 32'(busy), 32'd0);
        step(1); chk("drop_ch3_fw", 32'(firmware_clk), 32'hB);
        step(16); chk("drop_ch3_good", 32'(clk_good), 32'hB);
                  chk("drop_allg", 32'(all_good), 32'd1);

        // Restart (coincides with re-request of ch2) then full re-sequence
        #2 en_mask = 4'b1111; restart = 1'b1;
        step(1); chk("rs_good", 32'(clk_good), 32'h0);
                 chk("rs_fw", 32'(firmware_clk), 32'h0);
        #2 restart = 1'b0;
        seq_check("seq2");

        // Asynchronous reset in the middle of ch1 settle
        #2 restart = 1'b1;
        step(1); #2 restart = 1'b0;
        step(26); chk("mid_fw", 32'(firmware_clk), 32'h3);
        #2 rst_n = 1'b0;
        #1 chk("arst_fw", 32'(firmware_clk), 32'h0);
           chk("arst_good", 32'(clk_good), 32'h0);
           chk("arst_busy", 32'(busy), 32'd0);
        step(2);
        #2 rst_n = 1'b1;
        seq_check("seq3");

        #2 en_mask = 4'b0000;
        step(1); chk("zero_good", 32'(clk_good), 32'h0);
                 chk("zero_allg", 32'(all_good), 32'd0);
                 chk("zero_busy", 32'(busy), 32'd0);
                 chk("zero_div2", 32'(firmware_clk_div2), 32'h0);
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_gth_clk_import_seq.md
ADC_GTH_CLK_IMPORT_SEQ -- requirements
Module: adc_gth_clk_import_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of differential GTH reference-clock channels imported (1..16).
REQ-002 SHALL have parameter SETTLE_CYC, default 1024: clk cycles from a channel's buffer enable until its clock is declared good (2..65535).
REQ-003 SHALL have port clk  input  1: sequencer clock; all sequencer logic is in this single domain.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have ports adc_clk_p / adc_clk_n  input  N_CH each: differential reference-clock pairs, one bit per channel.
REQ-006 SHALL have port firmware_clk  output  N_CH: buffered clock per channel, taken from the O output of one IBUFDS_GTE4 per channel.
REQ-007 SHALL have port firmware_clk_div2  output  N_CH: per-channel ODIV2 output (see Configuration).
REQ-008 SHALL have port en_mask  input  N_CH: requested-enable mask, one bit per channel.
REQ-009 SHALL have port restart  input  1: single-cycle pulse; re-sequences all channels.
REQ-010 SHALL have port clk_good  output  N_CH: channel enabled and settled.
REQ-011 SHALL have port all_good  output  1: high when en_mask is nonzero and clk_good equals en_mask.
REQ-012 SHALL have port busy  output  1: sequencer is not in S_IDLE.

Function
REQ-013 SHALL drive each buffer's CEB as the inverse of an internal registered active[ch] bit; buffer attributes REFCLK_EN_TX_PATH=0, REFCLK_HROW_CK_SEL=2'b00, REFCLK_ICNTL_RX=2'b00.
REQ-014 SHALL implement FSM states S_IDLE and S_SETTLE; current channel index cur is held in a register of width clog2(N_CH), minimum 1.
REQ-015 In S_IDLE, when pending = en_mask & ~active is nonzero, SHALL pick the lowest-index pending channel, set active[cur]=1 and load the settle counter with SETTLE_CYC-1 on the next edge, and go to S_SETTLE.
REQ-016 Only one channel SHALL be in settle at a time, so consecutive channel enables are at least SETTLE_CYC+1 cycles apart (staggered inrush).
REQ-017 In S_SETTLE, the counter SHALL decrement each cycle; on the cycle it reads 0, clk_good[cur] SHALL be set and the FSM SHALL return to S_IDLE, giving good exactly SETTLE_CYC cycles after CEB falls.
REQ-018 When en_mask[ch] falls, active[ch] and clk_good[ch] SHALL clear on the next edge in any state; if ch==cur in S_SETTLE, the FSM SHALL abort to S_IDLE on the same edge without setting good.
REQ-019 When restart is high, all active and clk_good bits SHALL clear and the FSM SHALL enter S_IDLE on the next edge; restart takes priority over every other event.
REQ-020 When a channel drop and a new pending channel occur in the same cycle in S_IDLE, the clear and the new enable SHALL both take effect on that edge.
REQ-021 all_good and busy SHALL be combinational decodes of registered state.
REQ-022 en_mask SHALL be treated as synchronous to clk, with no internal synchroniser.

Reset
REQ-023 While rst_n is low: active=0 (all CEB=1), clk_good=0, all_good=0, busy=0, counter=0, cur=0, FSM=S_IDLE.
REQ-024 A reset asserted mid-settle SHALL abort the settle with no partial good bit; sequencing restarts from the lowest pending channel after rst_n rises.

Configuration
REQ-025 With macro ADC_GTH_CLK_IMPORT_ODIV2_EN defined, firmware_clk_div2[ch] SHALL be the buffer's ODIV2 output; without it, firmware_clk_div2 SHALL be tied to 0 and ODIV2 left unconnected.

Verification
REQ-026 N_CH=4, SETTLE_CYC=16, en_mask 0->4'b1111 -> CEB falls on ch0,1,2,3 at 17-cycle spacing; each clk_good is set 16 cycles after its CEB falls; all_good rises with clk_good[3]; busy is then low.
REQ-027 Ch2 in settle, en_mask[2] dropped at count 5 -> CEB[2]=1 on the next edge, clk_good[2] never set, FSM returns to S_IDLE, ch3 begins on the following cycle.
REQ-028 All good, then a restart pulse -> clk_good=0 and all CEB=1 after one edge; full re-sequence reproduces the REQ-026 timing.
REQ-029 rst_n pulsed low asynchronously mid-settle of ch1 -> outputs go to reset values immediately; after release, ch0 re-sequences first.
REQ-030 en_mask=0 -> all_good=0 and busy=0; with ADC_GTH_CLK_IMPORT_ODIV2_EN undefined, firmware_clk_div2=0.
